// File: rtl/hwpf_stride_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : hwpf_stride_req_gen
// Brief    : Stride prefetcher request generator. It arms the snooper and, on
//            a match, issues a burst of line prefetches at base+k*stride.
//            Optional macro HWPF_STRIDE_THROTTLE_EN inserts throttle gaps
//            between requests.
// Revision : 1.0 - initial release
// ============================================================================
module hwpf_stride_req_gen #(
  parameter int NLINE_W    = 34,
  parameter int STRIDE_W   = 16,
`ifdef HWPF_STRIDE_THROTTLE_EN
  parameter int THROTTLE_W = 4,
`endif
  parameter int NLINES_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                cfg_set_i,
  input  logic [NLINE_W-1:0]  cfg_base_nline_i,
  input  logic [STRIDE_W-1:0] cfg_stride_i,
  input  logic [NLINES_W-1:0] cfg_nlines_i,
  input  logic                cfg_rearm_i,
  input  logic                snoop_match_i,
`ifdef HWPF_STRIDE_THROTTLE_EN
  input  logic [THROTTLE_W-1:0] throttle_i,
`endif
  output logic                snoop_en_o,
  output logic [NLINE_W-1:0]  base_nline_o,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic [NLINE_W-1:0]  req_nline_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
`ifdef HWPF_STRIDE_THROTTLE_EN
    ST_WAIT  = 2'd3,
`endif
    ST_BURST = 2'd2
  } state_t;

  localparam logic [NLINES_W-1:0] c_count_one = {{(NLINES_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [NLINE_W-1:0]    r_base;
  logic [STRIDE_W-1:0]   r_stride;
  logic [NLINES_W-1:0]   r_nlines;
  logic                  r_rearm;
  logic                  r_cfg_loaded;
  logic [NLINE_W-1:0]    r_req_nline;
  logic [NLINES_W-1:0]   r_count;
  logic                  r_abort;
  logic                  r_done;
`ifdef HWPF_STRIDE_THROTTLE_EN
  localparam logic [THROTTLE_W-1:0] c_wait_one = {{(THROTTLE_W-1){1'b0}}, 1'b1};
  logic [THROTTLE_W-1:0] r_wait_cnt;
`endif

  logic [NLINE_W-1:0]    w_stride_ext;
  logic                  w_busy;

  assign w_stride_ext = {{(NLINE_W-STRIDE_W){r_stride[STRIDE_W-1]}}, r_stride};

  always_comb begin
    w_busy = (r_state == ST_BURST);
`ifdef HWPF_STRIDE_THROTTLE_EN
    w_busy = w_busy || (r_state == ST_WAIT);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_stride     <= '0;
      r_nlines     <= '0;
      r_rearm      <= 1'b0;
      r_cfg_loaded <= 1'b0;
      r_req_nline  <= '0;
      r_count      <= '0;
      r_abort      <= 1'b0;
      r_done       <= 1'b0;
`ifdef HWPF_STRIDE_THROTTLE_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (cfg_set_i && !w_busy) begin
        r_base       <= cfg_base_nline_i;
        r_stride     <= cfg_stride_i;
        r_nlines     <= cfg_nlines_i;
        r_rearm      <= cfg_rearm_i;
        r_cfg_loaded <= 1'b1;
        r_state      <= enable_i ? ST_ARMED : ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (enable_i && r_cfg_loaded) r_state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (!enable_i) begin
              r_state <= ST_IDLE;
            end else if (snoop_match_i) begin
              if (r_nlines != '0) begin
                r_req_nline <= r_base + w_stride_ext;
                r_count     <= r_nlines;
                r_abort     <= 1'b0;
                r_state     <= ST_BURST;
              end else if (r_rearm) begin
                r_base <= r_base + w_stride_ext;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          ST_BURST: begin
            // A dip in enable is remembered so the burst ends at the next accept
            if (!enable_i) r_abort <= 1'b1;
            if (req_ready_i) begin
              r_req_nline <= r_req_nline + w_stride_ext;
              r_count     <= r_count - c_count_one;
              if (!enable_i || r_abort) begin
                r_count <= '0;
                r_state <= ST_IDLE;
              end else if (r_count == c_count_one) begin
                r_done <= 1'b1;
                if (r_rearm) begin
                  r_base  <= r_base + w_stride_ext;
                  r_state <= ST_ARMED;
                end else begin
                  r_state <= ST_IDLE;
                end
              end
`ifdef HWPF_STRIDE_THROTTLE_EN
              else if (throttle_i != '0) begin
                r_wait_cnt <= throttle_i;
                r_state    <= ST_WAIT;
              end
`endif
            end
          end
`ifdef HWPF_STRIDE_THROTTLE_EN
          ST_WAIT: begin
            if (!enable_i) begin
              r_state <= ST_IDLE;
            end else if (r_wait_cnt == c_wait_one) begin
              r_state <= ST_BURST;
            end else begin
              r_wait_cnt <= r_wait_cnt - c_wait_one;
            end
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign snoop_en_o   = (r_state == ST_ARMED) && enable_i;
  assign base_nline_o = r_base;
  assign req_valid_o  = (r_state == ST_BURST);
  assign req_nline_o  = r_req_nline;
  assign busy_o       = w_busy;
  assign done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hwpf_stride_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpf_stride_req_gen
// Brief    : Directed self-checking bench for hwpf_stride_req_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwpf_stride_req_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        cfg_set_i;
  logic [33:0] cfg_base_nline_i;
  logic [15:0] cfg_stride_i;
  logic [7:0]  cfg_nlines_i;
  logic        cfg_rearm_i;
  logic        snoop_match_i;
  logic        snoop_en_o;
  logic [33:0] base_nline_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [33:0] req_nline_o;
  logic        busy_o;
  logic        done_o;
`ifdef HWPF_STRIDE_THROTTLE_EN
  logic [3:0]  throttle_i;
`endif

  int total = 0;
  int bad   = 0;

  hwpf_stride_req_gen dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .cfg_set_i        (cfg_set_i),
    .cfg_base_nline_i (cfg_base_nline_i),
    .cfg_stride_i     (cfg_stride_i),
    .cfg_nlines_i     (cfg_nlines_i),
    .cfg_rearm_i      (cfg_rearm_i),
    .snoop_match_i    (snoop_match_i),
`ifdef HWPF_STRIDE_THROTTLE_EN
    .throttle_i       (throttle_i),
`endif
    .snoop_en_o       (snoop_en_o),
    .base_nline_o     (base_nline_o),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_nline_o      (req_nline_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [33:0] base, input logic [15:0] stride,
                     input logic [7:0] nl, input logic rearm);
    cfg_set_i        = 1'b1;
    cfg_base_nline_i = base;
    cfg_stride_i     = stride;
    cfg_nlines_i     = nl;
    cfg_rearm_i      = rearm;
    tick();
    cfg_set_i = 1'b0;
  endtask

  task automatic match();
    snoop_match_i = 1'b1;
    tick();
    snoop_match_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; cfg_set_i = 1'b0; cfg_base_nline_i = '0;
    cfg_stride_i = '0; cfg_nlines_i = '0; cfg_rearm_i = 1'b0;
    snoop_match_i = 1'b0; req_ready_i = 1'b1;
`ifdef HWPF_STRIDE_THROTTLE_EN
    throttle_i = '0;
`endif
    tick(); tick();
    chk("rst_valid", req_valid_o, 0);
    chk("rst_base", base_nline_o, 0);
    chk("rst_nline", req_nline_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_snoop", snoop_en_o, 0);
    rst_i = 1'b0;
    enable_i = 1'b1;
    tick();
    chk("noload_snoop", snoop_en_o, 0);

    // basic burst
    cfg(34'h100, 16'd2, 8'd3, 1'b0);
    chk("b_armed", snoop_en_o, 1);
    chk("b_base", base_nline_o, 34'h100);
    match();
    chk("b_v1", req_valid_o, 1);
    chk("b_n1", req_nline_o, 34'h102);
    chk("b_busy", busy_o, 1);
    chk("b_done_early", done_o, 0);
    tick();
    chk("b_n2", req_nline_o, 34'h104);
    tick();
    chk("b_n3", req_nline_o, 34'h106);
    tick();
    chk("b_done", done_o, 1);
    chk("b_v_end", req_valid_o, 0);
    chk("b_snoop_end", snoop_en_o, 0);
    chk("b_busy_end", busy_o, 0);
    tick();
    chk("b_done_pulse", done_o, 0);

    // re-arm
    cfg(34'h100, 16'd2, 8'd3, 1'b1);
    match();
    chk("r_n1", req_nline_o, 34'h102);
    tick(); tick(); tick();
    chk("r_done", done_o, 1);
    chk("r_base", base_nline_o, 34'h102);
    chk("r_snoop", snoop_en_o, 1);
    match();
    chk("r2_n1", req_nline_o, 34'h104);
    tick();
    chk("r2_n2", req_nline_o, 34'h106);
    tick();
    chk("r2_n3", req_nline_o, 34'h108);
    tick();
    chk("r2_done", done_o, 1);
    chk("r2_base", base_nline_o, 34'h104);

    // backpressure
    req_ready_i = 1'b0;
    cfg(34'h100, 16'd2, 8'd2, 1'b0);
    match();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", req_valid_o, 1);
      chk("bp_nline", req_nline_o, 34'h102);
      if (i < 4) tick();
    end
    req_ready_i = 1'b1;
    tick();
    chk("bp_n2_valid", req_valid_o, 1);
    chk("bp_n2", req_nline_o, 34'h104);
    tick();
    chk("bp_done", done_o, 1);

    // negative stride with wrap
    cfg(34'h1, 16'hFFFE, 8'd2, 1'b0);
    match();
    chk("neg_n1", req_nline_o, 34'h3FFFFFFFF);
    tick();
    chk("neg_n2", req_nline_o, 34'h3FFFFFFFD);
    tick();
    chk("neg_done", done_o, 1);

    // abort with ignored configuration
    req_ready_i = 1'b0;
    cfg(34'h200, 16'd1, 8'd4, 1'b1);
    match();
    chk("ab_n1", req_nline_o, 34'h201);
    cfg(34'h500, 16'h10, 8'd7, 1'b0);
    chk("ab_cfg_base", base_nline_o, 34'h200);
    chk("ab_cfg_nline", req_nline_o, 34'h201);
    chk("ab_busy", busy_o, 1);
    enable_i = 1'b0;
    tick();
    chk("ab_hold_valid", req_valid_o, 1);
    chk("ab_hold_nline", req_nline_o, 34'h201);
    req_ready_i = 1'b1;
    tick();
    chk("ab_valid_off", req_valid_o, 0);
    chk("ab_busy_off", busy_o, 0);
    chk("ab_no_done", done_o, 0);
    tick();
    chk("ab_no_done2", done_o, 0);
    chk("ab_base_kept", base_nline_o, 34'h200);
    chk("ab_snoop_off", snoop_en_o, 0);
    enable_i = 1'b1;
    tick();
    chk("ab_rearm_snoop", snoop_en_o, 1);
    req_ready_i = 1'b0;
    match();
    chk("ab_stride_kept", req_nline_o, 34'h201);

    // reset mid-burst
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mr_valid", req_valid_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_base", base_nline_o, 0);
    chk("mr_nline", req_nline_o, 0);
    tick();
    chk("mr_snoop", snoop_en_o, 0);

`ifdef HWPF_STRIDE_THROTTLE_EN
    // throttle gaps of two cycles
    req_ready_i = 1'b1;
    throttle_i  = 4'd2;
    cfg(34'h100, 16'd2, 8'd3, 1'b0);
    match();
    chk("th_v1", req_valid_o, 1);
    chk("th_n1", req_nline_o, 34'h102);
    tick();
    chk("th_gap1a", req_valid_o, 0);
    tick();
    chk("th_gap1b", req_valid_o, 0);
    tick();
    chk("th_v2", req_valid_o, 1);
    chk("th_n2", req_nline_o, 34'h104);
    tick();
    chk("th_gap2a", req_valid_o, 0);
    tick();
    chk("th_gap2b", req_valid_o, 0);
    tick();
    chk("th_v3", req_valid_o, 1);
    chk("th_n3", req_nline_o, 34'h106);
    tick();
    chk("th_done", done_o, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hwpf_stride_req_gen.md
Name: hwpf_stride_req_gen

Overview:
- Per-engine request generator of the stride hardware prefetcher; sits directly downstream of the stride snooper.
- Drives the snooper's base line and enable, consumes its match flag, and issues a burst of cache-line prefetch requests at base+stride, base+2*stride, and so on.
- Requests go over a valid/ready handshake to the prefetch arbiter.
- Re-arms itself one stride ahead so that a sequential stream keeps triggering.

Parameters:
NLINE_W, 34, width of a cache-line address (nline)
STRIDE_W, 16, width of the signed stride, in cache lines
NLINES_W, 8, width of the per-trigger request count
THROTTLE_W, 4, width of the throttle delay (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
enable_i  in  1  engine enable
cfg_set_i  in  1  load configuration (1-cycle strobe)
cfg_base_nline_i  in  NLINE_W  trigger line address
cfg_stride_i  in  STRIDE_W  signed stride in lines
cfg_nlines_i  in  NLINES_W  requests per trigger
cfg_rearm_i  in  1  after a burst, advance base by stride and re-arm; otherwise go idle
snoop_match_i  in  1  match flag from the snooper
snoop_en_o  out  1  enable to the snooper
base_nline_o  out  NLINE_W  base line to the snooper
req_valid_o  out  1  prefetch request valid
req_ready_i  in  1  prefetch request accepted
req_nline_o  out  NLINE_W  prefetch line address
busy_o  out  1  burst in progress
done_o  out  1  1-cycle pulse after the last request of a burst is accepted

Behaviour:
- Reset values: state IDLE; base_nline_o, req_nline_o, stride, count all 0; snoop_en_o, req_valid_o, busy_o, done_o all 0.
- States: IDLE, ARMED, BURST, plus WAIT with the optional feature.
- snoop_en_o = (state==ARMED) && enable_i.
- busy_o = (state is BURST or WAIT).
- cfg_set_i when busy_o=0:
  - Registers base, stride, nlines and the rearm flag.
  - Next state is ARMED if enable_i=1, else IDLE.
- cfg_set_i when busy_o=1: ignored.
- IDLE -> ARMED: on enable_i=1 with a configuration loaded since reset.
- ARMED, enable_i=0: go to IDLE.
- ARMED, snoop_match_i=1:
  - nlines!=0: req_nline <= base+stride, count <= nlines, go to BURST. req_valid_o rises the cycle after the match, i.e. 1-cycle latency.
  - nlines==0: no requests and no done_o. Base advances by stride if rearm=1 (stay ARMED), else go to IDLE.
- ARMED, snoop_match_i while snoop_en_o=0: ignored.
- BURST:
  - req_valid_o=1.
  - On req_valid_o && req_ready_i: req_nline += stride, count -= 1.
  - On the handshake with count==1: done_o pulses the next cycle. Then, if rearm=1, base += stride and go to ARMED; else go to IDLE.
- Valid stability: req_valid_o and req_nline_o are held stable until accepted.
- enable_i falls during BURST:
  - The currently asserted request is held until accepted, then go to IDLE.
  - No done_o; remaining count is discarded.
- snoop_match_i during BURST or WAIT: ignored (snoop_en_o=0).
- Arithmetic:
  - Stride is two's complement, sign-extended to NLINE_W.
  - All address sums wrap modulo 2^NLINE_W; no saturation, no error.
- Reset mid-burst: everything returns to reset values on the next edge. req_valid_o drops even if the request was not accepted.

Optional Feature:
- Macro: HWPF_STRIDE_THROTTLE_EN.
- Defined:
  - Adds input port throttle_i (THROTTLE_W) and state WAIT.
  - After each accepted request that is not the last, go to WAIT with req_valid_o=0 for throttle_i cycles, sampled at the handshake, then return to BURST.
  - throttle_i==0 gives back-to-back requests.
  - enable_i falling in WAIT goes to IDLE immediately.
- Undefined: port and WAIT state are absent; requests are back-to-back while req_ready_i=1.

Test Plan:
- Basic burst:
  - Stimulus: base=0x100, stride=+2, nlines=3, rearm=0, ready=1; match at cycle t.
  - Response: req_nline 0x102, 0x104, 0x106 in cycles t+1..t+3; done_o at t+4; state IDLE; snoop_en_o=0.
- Re-arm:
  - Stimulus: same configuration with rearm=1.
  - Response: after done_o, base_nline_o=0x102 and snoop_en_o=1. A second match yields 0x104, 0x106, 0x108.
- Backpressure:
  - Stimulus: ready=0 for 5 cycles after valid rises.
  - Response: req_valid_o=1 and req_nline_o=0x102 held stable for all 5 cycles; progress resumes when ready=1.
- Negative stride with wrap:
  - Stimulus: base=0x1, stride=-2, nlines=2.
  - Response: requests 0x3FFFFFFFF, then 0x3FFFFFFFD.
- Abort and ignored configuration:
  - Stimulus: during BURST, pulse cfg_set_i, then drop enable_i while ready=0; later raise ready.
  - Response: configuration unchanged; one pending request completes; no done_o; state IDLE.
- Throttle (HWPF_STRIDE_THROTTLE_EN):
  - Stimulus: throttle_i=2, nlines=3, ready=1.
  - Response: request handshakes at t+1, t+4, t+7.
